muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//  Multicycle signed MULT/DIV engine, started by the main control FSM for funct MULT (011000) / DIV (011010).
//  Takes A/B register values; produces the HI/LO pair that MFHI/MFLO read.
//  Iterative: one partial product / restoring-division step per clock; start/busy/done handshake to control FSM.
// PARAMETERS
//  WIDTH   32   operand width; HI/LO are WIDTH each, product is 2*WIDTH
// PORTS
//  clock     in   1      single clock, all state updates on posedge
//  reset     in   1      synchronous, active-high; sampled on posedge clock
//  start     in   1      request; sampled only in IDLE
//  op        in   1      0 = MULT, 1 = DIV; sampled with start
//  a_in      in   WIDTH  rs value (multiplicand / dividend), two's complement
//  b_in      in   WIDTH  rt value (multiplier / divisor), two's complement
//  busy      out  1      high from cycle after accepted start until DONE state exits
//  done      out  1      one-cycle pulse; hi_out/lo_out valid in and after this cycle
//  div_zero  out  1      one-cycle pulse coincident with done when DIV and b_in==0
//  hi_out    out  WIDTH  HI register (product upper / remainder)
//  lo_out    out  WIDTH  LO register (product lower / quotient)
// BEHAVIOUR
//  Reset (any state, incl. mid-operation): state=IDLE; busy=0, done=0, div_zero=0, hi_out=0, lo_out=0; counter and internal operands cleared.
//  States: IDLE -> RUN -> FIX -> DONE -> IDLE; IDLE -> DONE for divide-by-zero.
//  IDLE: busy=0. On start=1:
//   - op=DIV and b_in==0: -> DONE with div_zero flag set; hi_out/lo_out unchanged.
//   - else latch |a_in|, |b_in| (WIDTH-bit unsigned magnitudes) and result sign bits; counter=WIDTH-1; -> RUN.
//   - a_in/b_in/op are sampled only at this edge; later changes are ignored.
//  RUN: one step per cycle for WIDTH cycles; counter decrements, exit to FIX when counter==0 after step.
//   - MULT: shift-add over 2*WIDTH-bit unsigned accumulator.
//   - DIV: restoring division; remainder WIDTH+1 bits, quotient shifts in 1 bit per step.
//  FIX: apply signs, write HI/LO:
//   - MULT: {hi,lo} = signed 2*WIDTH product (negate if sign(a)^sign(b)).
//   - DIV: lo = quotient truncated toward zero (negate if sign(a)^sign(b)); hi = remainder, sign of dividend.
//   - -2^(W-1) / -1: lo = 0x80000000 (wrap), hi = 0; no flag.
//  DONE: done=1 for exactly this cycle; div_zero=1 only on the zero-divisor path; -> IDLE.
//  Latency: start sampled at edge t -> done high in cycle t+WIDTH+2 (34 cycles @32); div-by-zero: done in cycle t+1.
//  busy=1 in RUN, FIX, DONE. start while busy is ignored (not queued).
//  Back-to-back: start asserted in the cycle after DONE (state=IDLE) is accepted.
//  hi_out/lo_out hold their values between operations; only FIX writes them.
// STRUCTURE
//  Shared package: state encoding (IDLE, RUN, FIX, DONE), OP_MULT/OP_DIV, MULT_FUNCT/DIV_FUNCT constants shared with the control FSM.
//  Single module; optional combinational sub-module muldiv_step (one shift-add / restore step) for reuse.
//  Counter width $clog2(WIDTH).
// TESTING
//  1 MULT 7 x -3 -> done at cycle t+34, hi=0xFFFFFFFF, lo=0xFFFFFFEB, div_zero=0.
//  2 DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV 7 / -2 -> lo=0xFFFFFFFD, hi=0x00000001.
//  3 DIV x / 0 (hi=0x11, lo=0x22 beforehand) -> done and div_zero high in cycle t+1, hi/lo still 0x11/0x22.
//  4 MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
//  5 reset asserted 10 cycles into a MULT -> next cycle busy=0, hi=lo=0; no done pulse ever follows.
//  6 start pulsed while busy -> ignored, result unchanged; start in cycle after done -> accepted, second result correct.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared constants and state encoding for the MULT/DIV sequencer.
// Funct codes are shared with the main control FSM.
package muldiv_sequencer_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX,
      S_DONE
   } state_t;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   localparam logic [5:0] MULT_FUNCT = 6'b011000;
   localparam logic [5:0] DIV_FUNCT  = 6'b011010;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring divide.
// acc holds {partial/remainder, multiplier/quotient}.
import muldiv_sequencer_pkg::*;

module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic               op,
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   divisor,
   output logic [2*WIDTH-1:0] acc_next
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] diff;
   logic             ge;

   assign sum    = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + (acc[0] ? {1'b0, divisor} : '0);
   assign rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign ge     = rem_sh >= {1'b0, divisor};
   // A successful subtract always leaves less than the divisor, so W bits suffice.
   assign diff   = rem_sh[WIDTH-1:0] - divisor;

   always_comb begin
      acc_next = {sum, acc[WIDTH-1:1]};
      if (op == OP_DIV)
         acc_next = {ge ? diff : rem_sh[WIDTH-1:0],
                     acc[WIDTH-2:0], ge};
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multicycle signed MULT/DIV engine producing HI/LO.
// One step per clock on magnitudes; signs applied in FIX.
import muldiv_sequencer_pkg::*;

module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   localparam int CW = $clog2(WIDTH);

   state_t             state;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   a_abs;
   logic [WIDTH-1:0]   b_abs;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
   logic               op_q;
   logic               neg_res;
   logic               neg_rem;

   assign a_abs = a_in[WIDTH-1] ? -a_in : a_in;
   assign b_abs = b_in[WIDTH-1] ? -b_in : b_in;
   assign prod  = neg_res ? -acc : acc;
   assign quo   = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem   = neg_rem ? -acc[2*WIDTH-1:WIDTH]
                          : acc[2*WIDTH-1:WIDTH];

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .op       (op_q),
      .acc      (acc),
      .divisor  (b_mag),
      .acc_next (acc_next)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= S_IDLE;
         count    <= '0;
         acc      <= '0;
         b_mag    <= '0;
         op_q     <= OP_MULT;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi_out   <= '0;
         lo_out   <= '0;
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (op == OP_DIV && b_in == '0) begin
                     done     <= 1'b1;
                     div_zero <= 1'b1;
                     state    <= S_DONE;
                  end else begin
                     acc     <= {{WIDTH{1'b0}}, a_abs};
                     b_mag   <= b_abs;
                     op_q    <= op;
                     neg_res <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                     neg_rem <= a_in[WIDTH-1];
                     count   <= CW'(WIDTH - 1);
                     state   <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               acc   <= acc_next;
               count <= count - 1'b1;
               if (count == '0)
                  state <= S_FIX;
            end
            S_FIX: begin
               if (op_q == OP_DIV) begin
                  hi_out <= rem;
                  lo_out <= quo;
               end else begin
                  {hi_out, lo_out} <= prod;
               end
               done  <= 1'b1;
               state <= S_DONE;
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
